// File: rtl/output_pkg.sv
// rtl/output_pkg.sv - shared FSM states, sizing defaults and program image for output_collector
package output_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEPTH_DEFAULT = 16;
  localparam int CNT_W_DEFAULT = 8;

  // Expected program output image, one 3-bit word per emitted value.
  localparam int PROG_LEN = 8;
  localparam int PROG_AW  = $clog2(PROG_LEN);
  localparam logic [2:0] PROG_ROM [0:PROG_LEN-1] = '{
    3'd3, 3'd5, 3'd0, 3'd7, 3'd1, 3'd6, 3'd2, 3'd4
  };

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two FIFO with registered head, no fall-through
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 3,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/output_collector.sv
// rtl/output_collector.sv - buffers program output, drains on halt; QUINE_CHECK_EN adds image compare
module output_collector
  import output_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       in_data,
  input  logic             in_valid,
  input  logic             halt_in,
  output logic [2:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             done,
  output logic [CNT_W-1:0] emit_cnt,
  output logic             quine_ok
);

  state_e           state_q, state_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] emit_cnt_q, emit_cnt_d;
  logic             push, pop, full, empty;
  logic [2:0]       head;

  sync_fifo #(
    .DEPTH(DEPTH),
    .W    (3)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(in_data),
    .pop  (pop),
    .full (full),
    .empty(empty),
    .head (head)
  );

  assign out_valid = !empty && (state_q != ST_DONE);
  assign out_data  = out_valid ? head : 3'd0;
  assign pop       = out_valid && out_ready;
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign push      = (state_q == ST_RUN) && in_valid && (!full || pop);

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    emit_cnt_d = emit_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (in_valid && full && !pop) overflow_d = 1'b1;
        if (halt_in) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (empty) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
    if (pop && (emit_cnt_q != '1)) emit_cnt_d = emit_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      overflow_q <= 1'b0;
      emit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      emit_cnt_q <= emit_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign done     = (state_q == ST_DONE);
  assign emit_cnt = emit_cnt_q;

`ifdef QUINE_CHECK_EN
  logic match_q, match_d;

  // Index the image by the count of values already popped.
  always_comb begin
    match_d = match_q;
    if (pop) begin
      if (emit_cnt_q >= CNT_W'(PROG_LEN)) begin
        match_d = 1'b0;
      end else if (out_data != PROG_ROM[emit_cnt_q[PROG_AW-1:0]]) begin
        match_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match_q <= 1'b1;
    else        match_q <= match_d;
  end

  assign quine_ok = match_q && done && (emit_cnt_q == CNT_W'(PROG_LEN));
`else
  assign quine_ok = 1'b0;
`endif

endmodule

// File: tb/tb_output_collector.sv
// tb/tb_output_collector.sv - vector table, directed corner sequences and random run against a queue model
module tb_output_collector;
  import output_pkg::*;

  localparam int DEPTH   = 16;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef QUINE_CHECK_EN
  localparam int QUINE_EXP = 1;
`else
  localparam int QUINE_EXP = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             halt_in = 1'b0;
  logic [2:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             overflow;
  logic             done;
  logic [CNT_W-1:0] emit_cnt;
  logic             quine_ok;

  always #5 clk = ~clk;

  output_collector #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .halt_in  (halt_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow),
    .done     (done),
    .emit_cnt (emit_cnt),
    .quine_ok (quine_ok)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    halt_in   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit iv; int id; bit h; bit rdy;
    bit ev; int ed; bit eo; bit edn; int ec;
  } vec_t;

  function automatic vec_t mk(bit iv, int id, bit h, bit rdy, bit ev, int ed, bit eo, bit edn, int ec);
    vec_t v;
    v.iv = iv; v.id = id; v.h = h; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.eo = eo; v.edn = edn; v.ec = ec;
    return v;
  endfunction

  // Reference model: a plain queue plus mode 0=run, 1=drain, 2=done.
  int mq[$];
  int m_mode;
  bit m_ovf;
  int m_pops;
  bit m_match;

  task automatic model_reset();
    mq.delete();
    m_mode  = 0;
    m_ovf   = 1'b0;
    m_pops  = 0;
    m_match = 1'b1;
  endtask

  task automatic model_edge();
    int pre_size;
    bit pop_now;
    pre_size = mq.size();
    pop_now  = (pre_size > 0) && (m_mode != 2) && out_ready;
    if (pop_now) begin
      if (m_pops >= PROG_LEN) m_match = 1'b0;
      else if (mq[0] != int'(PROG_ROM[m_pops])) m_match = 1'b0;
      void'(mq.pop_front());
      m_pops++;
    end
    if (m_mode == 0 && in_valid) begin
      if (pre_size < DEPTH || pop_now) mq.push_back(int'(in_data));
      else m_ovf = 1'b1;
    end
    if (m_mode == 0 && halt_in) m_mode = 1;
    else if (m_mode == 1 && pre_size == 0) m_mode = 2;
  endtask

  task automatic model_compare();
    int ev, ed, ec, eq;
    ev = (mq.size() > 0 && m_mode != 2) ? 1 : 0;
    ed = ev ? mq[0] : 0;
    ec = (m_pops > CNT_MAX) ? CNT_MAX : m_pops;
    eq = (QUINE_EXP == 1 && m_match && m_mode == 2 && m_pops == PROG_LEN) ? 1 : 0;
    chk("rnd_valid", int'(out_valid), ev);
    chk("rnd_data", int'(out_data), ed);
    chk("rnd_overflow", int'(overflow), int'(m_ovf));
    chk("rnd_done", int'(done), (m_mode == 2) ? 1 : 0);
    chk("rnd_emit_cnt", int'(emit_cnt), ec);
    chk("rnd_quine_ok", int'(quine_ok), eq);
  endtask

  task automatic run_image(input int corrupt_idx);
    int guard;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < PROG_LEN; i++) begin
      in_valid = 1'b1;
      in_data  = (i == corrupt_idx) ? (PROG_ROM[i] ^ 3'd1) : PROG_ROM[i];
      halt_in  = (i == PROG_LEN - 1);
      step();
    end
    in_valid = 1'b0;
    halt_in  = 1'b0;
    guard = 0;
    while (!done && guard < 50) begin
      step();
      guard++;
    end
    chk("image_done_reached", int'(done), 1);
    chk("image_emit_cnt", int'(emit_cnt), PROG_LEN);
    chk("image_quine_ok", int'(quine_ok), (corrupt_idx < 0) ? QUINE_EXP : 0);
  endtask

  vec_t tbl[13];

  initial begin
    int n_drained;
    int last_val;
    int first_val;

    tbl[0]  = mk(1, 3, 0, 1,  1, 3, 0, 0, 0);
    tbl[1]  = mk(1, 5, 0, 1,  1, 5, 0, 0, 1);
    tbl[2]  = mk(1, 0, 0, 1,  1, 0, 0, 0, 2);
    tbl[3]  = mk(0, 0, 0, 1,  0, 0, 0, 0, 3);
    tbl[4]  = mk(1, 2, 0, 0,  1, 2, 0, 0, 3);
    tbl[5]  = mk(1, 6, 0, 0,  1, 2, 0, 0, 3);
    tbl[6]  = mk(1, 1, 1, 0,  1, 2, 0, 0, 3);
    tbl[7]  = mk(1, 4, 0, 1,  1, 6, 0, 0, 4);
    tbl[8]  = mk(0, 0, 0, 1,  1, 1, 0, 0, 5);
    tbl[9]  = mk(0, 0, 0, 1,  0, 0, 0, 0, 6);
    tbl[10] = mk(1, 7, 0, 1,  0, 0, 0, 1, 6);
    tbl[11] = mk(1, 3, 0, 1,  0, 0, 0, 1, 6);
    tbl[12] = mk(0, 0, 1, 1,  0, 0, 0, 1, 6);

    do_reset();
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_data", int'(out_data), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_emit_cnt", int'(emit_cnt), 0);
    chk("reset_quine_ok", int'(quine_ok), 0);

    // Stream 3,5,0 then push 2, halt with a simultaneous push, drain to done.
    for (int i = 0; i < 13; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = 3'(tbl[i].id);
      halt_in   = tbl[i].h;
      out_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
      chk($sformatf("vec%0d_data", i), int'(out_data), tbl[i].ed);
      chk($sformatf("vec%0d_overflow", i), int'(overflow), int'(tbl[i].eo));
      chk($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].edn));
      chk($sformatf("vec%0d_emit_cnt", i), int'(emit_cnt), tbl[i].ec);
      chk($sformatf("vec%0d_quine_ok", i), int'(quine_ok), 0);
    end

    // Seventeen pushes without a consumer: the last one is dropped.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 3'(i % 8);
      step();
      if (i == 15) chk("ovf_after_16", int'(overflow), 0);
      if (i == 16) chk("ovf_after_17", int'(overflow), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_drain%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("ovf_drain%0d_data", i), int'(out_data), i % 8);
      step();
    end
    chk("ovf_drained_empty", int'(out_valid), 0);
    chk("ovf_sticky", int'(overflow), 1);
    chk("ovf_emit_cnt", int'(emit_cnt), 16);

    // Full FIFO with simultaneous push and pop keeps all 16 slots in use.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 3'(i % 8);
      step();
    end
    chk("full_no_ovf", int'(overflow), 0);
    out_ready = 1'b1;
    in_data   = 3'd5;
    step();
    in_valid = 1'b0;
    chk("fullpp_no_ovf", int'(overflow), 0);
    chk("fullpp_emit_cnt", int'(emit_cnt), 1);
    n_drained = 0;
    last_val  = -1;
    first_val = -1;
    while (out_valid && n_drained < 40) begin
      if (n_drained == 0) first_val = int'(out_data);
      last_val = int'(out_data);
      n_drained++;
      step();
    end
    chk("fullpp_occupancy", n_drained, 16);
    chk("fullpp_first", first_val, 1);
    chk("fullpp_last", last_val, 5);

    // Asynchronous reset with five values buffered.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data  = 3'(i);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("midrst_pre_emit", int'(emit_cnt), 1);
    chk("midrst_pre_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(out_data), 0);
    chk("midrst_emit_cnt", int'(emit_cnt), 0);
    chk("midrst_done", int'(done), 0);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("midrst_no_stale_valid", int'(out_valid), 0);
    chk("midrst_no_stale_emit", int'(emit_cnt), 0);
    in_valid = 1'b1;
    in_data  = 3'd4;
    step();
    in_valid = 1'b0;
    chk("midrst_run_valid", int'(out_valid), 1);
    chk("midrst_run_data", int'(out_data), 4);
    step();
    chk("midrst_run_emit", int'(emit_cnt), 1);

    // Program image, exact and with one corrupted word.
    run_image(-1);
    run_image(3);

    // Random traffic: congested phase, free-flowing phase, then halt.
    do_reset();
    model_reset();
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 3'($urandom_range(0, 7));
      out_ready = (i < 200) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 9);
      halt_in   = (i >= 780) || ((i >= 700) && ($urandom_range(0, 19) == 0));
      model_edge();
      step();
      model_compare();
    end
    chk("rnd_final_done", int'(done), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/output_collector.md
OUTPUT_COLLECTOR -- requirements
Module: output_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 4..64.
REQ-002 SHALL have parameter CNT_W, default 8, width of the emitted-output counter.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  3  program output value from execute stage (reg_out).
REQ-006 in_valid  input  1  one-cycle strobe from execute stage (out_valid).
REQ-007 halt_in  input  1  execute-stage halt indication.
REQ-008 out_data  output  3  head-of-FIFO value.
REQ-009 out_valid  output  1  out_data holds an unread value.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 overflow  output  1  sticky; a value was dropped.
REQ-012 done  output  1  program halted and all values drained.
REQ-013 emit_cnt  output  CNT_W  count of values popped, saturating.
REQ-014 quine_ok  output  1  popped stream equals program image (see Configuration).

Function
REQ-015 FSM states RUN, DRAIN, DONE; reset state RUN.
REQ-016 RUN: in_valid pushes in_data if not full or if a pop occurs the same cycle.
REQ-017 RUN: in_valid while full with no same-cycle pop drops the value and sets overflow.
REQ-018 RUN -> DRAIN when halt_in=1; an in_valid in that same cycle is still pushed.
REQ-019 DRAIN: in_valid ignored; -> DONE when FIFO empty.
REQ-020 DONE: terminal until reset; done=1, out_valid=0.
REQ-021 out_valid = FIFO not empty (and state != DONE); out_data from registered head, no fall-through: a push into an empty FIFO is visible at out_valid the next cycle.
REQ-022 Pop occurs when out_valid and out_ready; out_data/out_valid SHALL remain stable while out_valid and not out_ready.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; occupancy tracked with log2(DEPTH)+1 bits.
REQ-024 emit_cnt increments per pop, saturates at 2^CNT_W-1.

Reset
REQ-025 Asynchronous reset SHALL clear pointers, occupancy, FSM=RUN, out_valid=0, out_data=0, overflow=0, done=0, emit_cnt=0, quine_ok as per REQ-027/028.
REQ-026 Reset mid-operation SHALL discard all buffered values; no pop visible afterwards.

Configuration
REQ-027 Macro QUINE_CHECK_EN defined: each pop compares out_data with PROG_ROM[emit_cnt]; any mismatch or pop beyond PROG_LEN clears a sticky match flag (reset 1); quine_ok = match AND done AND emit_cnt==PROG_LEN.
REQ-028 QUINE_CHECK_EN undefined: no comparison logic; quine_ok tied 0.

Structure
REQ-029 Shared package output_pkg SHALL hold FSM state encodings, DEPTH default, PROG_LEN and PROG_ROM (3-bit program words).
REQ-030 Storage and pointers SHALL be a sub-module sync_fifo (push, pop, full, empty, head); FSM, counters and checker in output_collector.

Verification
REQ-031 Push 3,5,0 with out_ready=1 -> out_data 3,5,0 on consecutive cycles starting one cycle after first push; emit_cnt=3.
REQ-032 out_ready=0, push 17 values (DEPTH=16) -> overflow=1 on 17th, first 16 values later drained in order.
REQ-033 Full FIFO, push and pop same cycle -> push accepted, occupancy stays 16, overflow stays 0.
REQ-034 Push 2 values, halt_in=1 with simultaneous push -> 3 values drained, then done=1, out_valid=0; later in_valid ignored.
REQ-035 QUINE_CHECK_EN, stream equals PROG_ROM then halt -> quine_ok=1; one corrupted value -> quine_ok=0.
REQ-036 Assert rst_n low with 5 values buffered -> out_valid=0, emit_cnt=0, state RUN immediately.
